rv32im_dmem_if: RTL
===================

Name: rv32im_dmem_if

Overview:
Data-memory bus interface stage, directly downstream of the rv32im execute unit's LSU outputs.
- Consumes the execute unit's memory request: enable, address, write data and byte mask.
- Runs a request/grant + response handshake to the data memory.
- Holds the core with stall_o until the access completes.
- Returns the raw read word to the execute unit's memory-read-data input.

Parameters:
ADDR_W, 32, address width; equals `API_ADDR_WIDTH
DATA_W, 32, data width; equals `API_DATA_WIDTH
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before abort (only with DMEM_TIMEOUT_EN)
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_ni  in  1  reset; asynchronous, active-low
req_en_i  in  1  memory access request from execute unit
req_addr_i  in  ADDR_W  byte address from execute unit
req_wdata_i  in  DATA_W  lane-aligned store data
req_wmask_i  in  4  byte write mask; 4'b0000 = load, nonzero = store
req_rdata_o  out  DATA_W  raw word read; valid when done_o=1
stall_o  out  1  freeze PC/pipeline while high
done_o  out  1  one-cycle pulse: access finished
err_o  out  1  one-cycle pulse: access aborted by timeout
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  ADDR_W  word-aligned address
dmem_be_o  out  4  byte enables; 4'b1111 for loads
dmem_wdata_o  out  DATA_W  write data
dmem_gnt_i  in  1  bus accepts request in the cycle it is high with dmem_req_o
dmem_rvalid_i  in  1  response valid; loads and stores both get exactly one response
dmem_rdata_i  in  DATA_W  response data; ignored for stores

Behaviour:
- Clock and reset: one clock (clk_i). Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0; captured registers 0; counter 0.
- State IDLE:
  - stall_o = req_en_i (combinational), so the core freezes in the same cycle the request appears.
  - On req_en_i=1: capture the request and go to REQ.
    - addr captured as {req_addr_i[ADDR_W-1:2],2'b00}.
    - we captured as |req_wmask_i.
    - be captured as req_wmask_i for stores, 4'b1111 for loads.
    - wdata captured from req_wdata_i.
  - dmem_rvalid_i arriving in IDLE (stray or late) is ignored.
- State REQ:
  - dmem_req_o=1; dmem_addr/we/be/wdata driven from registers and held stable until grant.
  - stall_o=1.
  - dmem_gnt_i=1: go to RESP.
- State RESP:
  - dmem_req_o=0; stall_o=1.
  - dmem_rvalid_i=1: register dmem_rdata_i (loads) or 0 (stores) into req_rdata_o; go to DONE.
  - rvalid is sampled only in RESP; rvalid coincident with gnt is a bus protocol violation and is not captured.
- State DONE:
  - stall_o=0; done_o=1; req_rdata_o valid.
  - Next state IDLE unconditionally.
  - req_en_i in DONE belongs to the finished instruction and is not re-captured.
- req_rdata_o holds its value until the next completion; it is cleared on err_o.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first RESP cycle:
  - cycle 0: request seen in IDLE, stall high.
  - cycles 1–2: REQ, then RESP.
  - cycle 3: done_o; stall low.
  - 3 stall cycles total.
- Reset mid-access: immediate return to IDLE with all outputs 0; the in-flight response is dropped.

Optional Feature:
Macro: DMEM_TIMEOUT_EN.
- Defined:
  - Counter clears on entering REQ and increments every cycle in REQ or RESP.
  - When counter==TIMEOUT_CYCLES and completion has not occurred: go to state ERR.
  - ERR lasts one cycle: err_o=1, stall_o=0, done_o=0, req_rdata_o=0, dmem_req_o=0. Next state IDLE.
  - gnt/rvalid arriving in the same cycle the timeout fires takes priority: normal completion.
- Not defined:
  - No counter and no ERR state; waits indefinitely.
  - err_o tied 0.

Test Plan:
- Load, zero wait: req_en=1, addr=0x0000_1006, mask=0; gnt in the first REQ cycle; rvalid next cycle with rdata=0xCAFE_F00D → dmem_addr_o=0x0000_1004, be=4'b1111, we=0; done_o at cycle 3 with req_rdata_o=0xCAFE_F00D; stall_o high cycles 0–2.
- Store with waits: mask=4'b1100, wdata=0xABCD_0000, gnt delayed 3 cycles, rvalid delayed 2 more → dmem_req_o high 4 cycles with stable addr/be/wdata, we=1; done_o once; req_rdata_o=0.
- Back-to-back: second req_en in the cycle after DONE → new capture and a single new bus request; no duplicate access for the first instruction.
- Stray rvalid in IDLE with req_en=0 → no state change; done_o=0; stall_o=0.
- Reset asserted in RESP → all outputs 0 asynchronously; a later rvalid is ignored; the next request completes normally.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted → err_o pulse at exactly cycle 5 after capture; stall_o low that cycle; req_rdata_o=0; return to IDLE.

Source files
------------

// File: rtl/rv32im_dmem_if.sv
// Data-memory bus interface: captures an LSU request, runs req/gnt + rvalid to memory, stalls the core until done.
// Optional abort on a bus timeout when DMEM_TIMEOUT_EN is defined.
module rv32im_dmem_if #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_en_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_wmask_i,
  output logic [DATA_W-1:0] req_rdata_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic capture_c;
  logic complete_c;
  logic busy_c;
  logic timeout_c;

  // Byte offset is dropped: the bus is word-addressed with byte enables.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign capture_c  = (state_q == S_IDLE) && req_en_i;
  assign complete_c = (state_q == S_RESP) && dmem_rvalid_i;
  assign busy_c     = (state_q == S_REQ) || (state_q == S_RESP);

  // The counter must be able to reach TIMEOUT_CYCLES.
  if (64'(TIMEOUT_CYCLES) >= (64'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("rv32im_dmem_if: CNT_W too small for TIMEOUT_CYCLES");
  end

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  // cnt_inc is the number of REQ+RESP cycles including the current one.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timeout_c = busy_c && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (capture_c) begin
      cnt_q <= '0;
    end else if (busy_c) begin
      cnt_q <= cnt_inc;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs; bus handshakes win over a coincident timeout
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = we_q;
    dmem_addr_o  = addr_q;
    dmem_be_o    = be_q;
    dmem_wdata_o = wdata_q;
    req_rdata_o  = rdata_q;
    case (state_q)
      S_IDLE: begin
        stall_o = req_en_i && rst_ni;
        if (req_en_i) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) begin
          state_d = S_RESP;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          state_d = S_DONE;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
`ifdef DMEM_TIMEOUT_EN
        err_o = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request capture; fields stay stable for the whole access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
    end else if (capture_c) begin
      addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
      we_q    <= |req_wmask_i;
      be_q    <= (|req_wmask_i) ? req_wmask_i : 4'b1111;
      wdata_q <= req_wdata_i;
    end
  end

  // Read data: loaded on completion (zero for stores), cleared on abort, held otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (complete_c) begin
      rdata_q <= we_q ? '0 : dmem_rdata_i;
    end else if (timeout_c && (state_d == S_ERR)) begin
      rdata_q <= '0;
    end
  end

endmodule
